led_pattern_ctrl: RTL and testbench

Multi-channel LED pattern generator, successor to the single fixed-interval blinker. A shared prescaler drives NUM_CH independent channels. Each channel is configured at runtime through a write port as OFF, ON, BLINK (symmetric toggle), or BURST (N pulses, then a pause). It sits between board status logic and the LED pins.

---
 rtl/led_pattern_pkg.sv | 21 ++
 rtl/led_pattern_chan.sv | 101 ++++++++++
 rtl/led_pattern_ctrl.sv | 83 ++++++++
 tb/tb_led_pattern_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pattern_pkg.sv
// Shared types and constants for the multi-channel LED pattern generator.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_BURST = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        BST_ON    = 2'd0,
        BST_OFF   = 2'd1,
        BST_PAUSE = 2'd2
    } burst_e;

    localparam int unsigned BRIGHT_W = 8;
    localparam int unsigned PWM_MAX  = 254;
    localparam int unsigned BURST_W  = 4;

endpackage

// File: rtl/led_pattern_chan.sv
// One LED channel: config registers, half-period counter and BURST sequencer.
module led_pattern_chan
    import led_pattern_pkg::*;
#(
    parameter int unsigned HALF_W       = 12,
    parameter int unsigned PAUSE_HALVES = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_tick,
    input  logic               i_restart,
    input  logic               i_wr,
    input  mode_e              i_mode,
    input  logic [HALF_W-1:0]  i_half,
    input  logic [BURST_W-1:0] i_burst,
    output logic               o_state
);

    localparam int unsigned PAUSE_W = (PAUSE_HALVES > 1) ? $clog2(PAUSE_HALVES) : 1;

    mode_e              r_mode;
    burst_e             r_bstate;
    logic [HALF_W-1:0]  r_half;
    logic [HALF_W-1:0]  r_half_cnt;
    logic [BURST_W-1:0] r_burst;
    logic [BURST_W-1:0] r_pulse_cnt;
    logic [PAUSE_W-1:0] r_pause_cnt;
    logic               r_state;

    mode_e              w_mode;
    logic               w_half_evt;
    logic               w_more_pulses;

    // Mode that the channel restarts into: the incoming one on a write, else the held one.
    assign w_mode        = i_wr ? i_mode : r_mode;
    assign w_half_evt    = i_tick && (r_half_cnt == r_half - HALF_W'(1));
    assign w_more_pulses = ({1'b0, r_pulse_cnt} + (BURST_W+1)'(1)) < {1'b0, r_burst};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode      <= MODE_OFF;
            r_half      <= HALF_W'(1);
            r_burst     <= BURST_W'(1);
            r_half_cnt  <= '0;
            r_pulse_cnt <= '0;
            r_pause_cnt <= '0;
            r_bstate    <= BST_ON;
            r_state     <= 1'b0;
        end else if (i_wr || i_restart) begin
            if (i_wr) begin
                r_mode  <= i_mode;
                r_half  <= (i_half == '0) ? HALF_W'(1) : i_half;
                r_burst <= (i_burst == '0) ? BURST_W'(1) : i_burst;
            end
            r_half_cnt  <= '0;
            r_pulse_cnt <= '0;
            r_pause_cnt <= '0;
            r_bstate    <= BST_ON;
            r_state     <= (w_mode != MODE_OFF);
        end else if (i_tick && (r_mode == MODE_BLINK || r_mode == MODE_BURST)) begin
            r_half_cnt <= w_half_evt ? '0 : r_half_cnt + HALF_W'(1);
            if (w_half_evt && r_mode == MODE_BLINK) begin
                r_state <= ~r_state;
            end else if (w_half_evt) begin
                // BURST: ON -> OFF -> (ON | PAUSE) -> ON
                case (r_bstate)
                    BST_ON: begin
                        r_bstate <= BST_OFF;
                        r_state  <= 1'b0;
                    end
                    BST_OFF: begin
                        r_pulse_cnt <= r_pulse_cnt + BURST_W'(1);
                        if (w_more_pulses) begin
                            r_bstate <= BST_ON;
                            r_state  <= 1'b1;
                        end else begin
                            r_bstate <= BST_PAUSE;
                        end
                    end
                    BST_PAUSE: begin
                        if (r_pause_cnt == PAUSE_W'(PAUSE_HALVES - 1)) begin
                            r_pause_cnt <= '0;
                            r_pulse_cnt <= '0;
                            r_bstate    <= BST_ON;
                            r_state     <= 1'b1;
                        end else begin
                            r_pause_cnt <= r_pause_cnt + PAUSE_W'(1);
                        end
                    end
                    default: begin
                        r_bstate <= BST_ON;
                        r_state  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/led_pattern_ctrl.sv
// Multi-channel LED pattern generator: shared prescaler, NUM_CH channels, optional PWM.
// Optional global brightness is enabled with `define LED_BRIGHTNESS_EN.
module led_pattern_ctrl
    import led_pattern_pkg::*;
#(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned PRESCALE     = 50_000,
    parameter int unsigned HALF_W       = 12,
    parameter int unsigned PAUSE_HALVES = 8,
    localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [HALF_W-1:0]   cfg_half,
    input  logic [BURST_W-1:0]  cfg_burst,
    input  logic                sync_in,
`ifdef LED_BRIGHTNESS_EN
    input  logic [BRIGHT_W-1:0] bright,
`endif
    output logic [NUM_CH-1:0]   led
);

    localparam int unsigned PRE_W = $clog2(PRESCALE);

    logic [PRE_W-1:0]  r_pre;
    logic              w_tick;
    logic [NUM_CH-1:0] w_wr;
    logic [NUM_CH-1:0] w_state;

    assign w_tick = (r_pre == PRE_W'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (rst || sync_in || w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    // Out-of-range cfg_ch matches no channel, so such writes fall away.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        assign w_wr[i] = cfg_we && (cfg_ch == CH_W'(i));

        led_pattern_chan #(
            .HALF_W       (HALF_W),
            .PAUSE_HALVES (PAUSE_HALVES)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .i_tick    (w_tick),
            .i_restart (sync_in),
            .i_wr      (w_wr[i]),
            .i_mode    (mode_e'(cfg_mode)),
            .i_half    (cfg_half),
            .i_burst   (cfg_burst),
            .o_state   (w_state[i])
        );
    end

`ifdef LED_BRIGHTNESS_EN
    logic [BRIGHT_W-1:0] r_pwm;
    logic [NUM_CH-1:0]   r_led;

    // Free-running 255-step PWM gates every channel by the global duty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm <= '0;
            r_led <= '0;
        end else begin
            r_pwm <= (r_pwm == BRIGHT_W'(PWM_MAX)) ? '0 : r_pwm + BRIGHT_W'(1);
            r_led <= w_state & {NUM_CH{(r_pwm < bright)}};
        end
    end

    assign led = r_led;
`else
    assign led = w_state;
`endif

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Self-checking bench for led_pattern_ctrl (PRESCALE=4, PAUSE_HALVES=4).
module tb_led_pattern_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_ch = '0;
    logic [1:0] cfg_mode = '0;
    logic [11:0] cfg_half = '0;
    logic [3:0] cfg_burst = '0;
    logic       sync_in = 1'b0;
    logic [7:0] bright = 8'd255;
    logic [3:0] led;
    logic [2:0] led3;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

`ifdef LED_BRIGHTNESS_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    always #5 clk = ~clk;

    led_pattern_ctrl #(.NUM_CH(4), .PRESCALE(4), .HALF_W(12), .PAUSE_HALVES(4)) u_dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
        .cfg_half(cfg_half), .cfg_burst(cfg_burst), .sync_in(sync_in),
`ifdef LED_BRIGHTNESS_EN
        .bright(bright),
`endif
        .led(led)
    );

    // Three-channel instance: cfg_ch=3 is out of range here.
    led_pattern_ctrl #(.NUM_CH(3), .PRESCALE(4), .HALF_W(12), .PAUSE_HALVES(4)) u_dut3 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
        .cfg_half(cfg_half), .cfg_burst(cfg_burst), .sync_in(sync_in),
`ifdef LED_BRIGHTNESS_EN
        .bright(bright),
`endif
        .led(led3)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Returns on the negedge where the written value is first visible.
    task automatic wr(input logic [1:0] ch, input logic [1:0] mode, input int half,
                      input int burst, input logic with_sync);
        cfg_we = 1'b1; cfg_ch = ch; cfg_mode = mode;
        cfg_half = 12'(half); cfg_burst = 4'(burst); sync_in = with_sync;
        @(negedge clk);
        cfg_we = 1'b0; sync_in = 1'b0;
        repeat (LAT - 1) @(negedge clk);
    endtask

    task automatic pulse_sync();
        sync_in = 1'b1;
        @(negedge clk);
        sync_in = 1'b0;
        repeat (LAT - 1) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [3:0] got;
        do_reset();
        checks++;
        if (led !== 4'b0000) begin
            errors++; $display("FAIL reset_initial got=%b exp=%b", led, 4'b0000);
        end
        wr(2'd0, 2'd2, 1, 1, 1'b0);
        pulse_sync();
        repeat (6) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) exp_q.push_back(4'b0000);
        while (exp_q.size() > 0) begin
            got = exp_q.pop_front();
            checks++;
            if (led !== got) begin
                errors++; $display("FAIL reset_hold got=%b exp=%b", led, got);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_blink();
        logic [3:0] e;
        do_reset();
        wr(2'd0, 2'd2, 3, 1, 1'b0);
        pulse_sync();
        for (int k = 0; k < 48; k++) exp_q.push_back({3'b000, ((k / 12) % 2 == 0)});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (led !== e) begin
                errors++; $display("FAIL blink got=%b exp=%b", led, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_burst();
        logic [3:0] e;
        int p;
        do_reset();
        wr(2'd1, 2'd3, 1, 2, 1'b0);
        pulse_sync();
        for (int k = 0; k < 64; k++) begin
            p = k % 32;
            exp_q.push_back({2'b00, (p < 4) || (p >= 8 && p < 12), 1'b0});
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (led !== e) begin
                errors++; $display("FAIL burst got=%b exp=%b", led, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_decode_on();
        logic [3:0] e;
        do_reset();
        wr(2'd2, 2'd1, 5, 1, 1'b0);
        checks++;
        if (led !== 4'b0100) begin
            errors++; $display("FAIL on_ch2 got=%b exp=%b", led, 4'b0100);
        end
        checks++;
        if (led3 !== 3'b100) begin
            errors++; $display("FAIL on_ch2_3ch got=%b exp=%b", led3, 3'b100);
        end
        wr(2'd3, 2'd1, 5, 1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (led3 !== 3'b100) begin
                errors++; $display("FAIL invalid_ch got=%b exp=%b", led3, 3'b100);
            end
            checks++;
            if (led !== 4'b1100) begin
                errors++; $display("FAIL on_ch3 got=%b exp=%b", led, 4'b1100);
            end
            @(negedge clk);
        end
        wr(2'd3, 2'd2, 0, 1, 1'b0);
        pulse_sync();
        for (int k = 0; k < 16; k++) exp_q.push_back({((k / 4) % 2 == 0), 3'b100});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (led !== e) begin
                errors++; $display("FAIL half_zero got=%b exp=%b", led, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mid_phase();
        do_reset();
        wr(2'd0, 2'd2, 3, 1, 1'b0);
        pulse_sync();
        repeat (5) @(negedge clk);
        checks++;
        if (led !== 4'b0001) begin
            errors++; $display("FAIL mid_high got=%b exp=%b", led, 4'b0001);
        end
        wr(2'd0, 2'd0, 3, 1, 1'b0);
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (led !== 4'b0000) begin
                errors++; $display("FAIL mid_off got=%b exp=%b", led, 4'b0000);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_collision();
        logic [3:0] e;
        do_reset();
        wr(2'd0, 2'd2, 2, 1, 1'b0);
        repeat (3) @(negedge clk);
        wr(2'd1, 2'd2, 1, 1, 1'b1);
        for (int k = 0; k < 32; k++)
            exp_q.push_back({2'b00, ((k / 4) % 2 == 0), ((k / 8) % 2 == 0)});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (led !== e) begin
                errors++; $display("FAIL collision got=%b exp=%b", led, e);
            end
            @(negedge clk);
        end
    endtask

`ifdef LED_BRIGHTNESS_EN
    task automatic test_brightness();
        int hi;
        do_reset();
        bright = 8'd128;
        wr(2'd2, 2'd1, 1, 1, 1'b0);
        repeat (3) @(negedge clk);
        hi = 0;
        for (int k = 0; k < 255; k++) begin
            if (led[2] === 1'b1) hi++;
            @(negedge clk);
        end
        checks++;
        if (hi != 128) begin
            errors++; $display("FAIL bright128 got=%0d exp=%0d", hi, 128);
        end
        bright = 8'd0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (led !== 4'b0000) begin
                errors++; $display("FAIL bright0 got=%b exp=%b", led, 4'b0000);
            end
            @(negedge clk);
        end
        bright = 8'd255;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 300; k++) begin
            checks++;
            if (led !== 4'b0100) begin
                errors++; $display("FAIL bright255 got=%b exp=%b", led, 4'b0100);
            end
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_blink();
        test_burst();
        test_decode_on();
        test_mid_phase();
        test_collision();
`ifdef LED_BRIGHTNESS_EN
        test_brightness();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
